// File: rtl/weight_sram_arbiter.sv
// weight_sram_arbiter
// Shares one weight SRAM read port among NUM_PU unique-weight-buffer
// requesters. One read is in flight at a time: IDLE picks a winner, ISSUE
// strobes the SRAM, WAIT counts SRAM_LAT cycles and captures the word,
// RETURN pulses the winner's word_ready with the captured word on SRAM_out.
//
// Configuration macro: WEIGHT_ARB_FIXED_PRIORITY_EN
//   undefined (default) : round-robin arbitration via rr_ptr
//   defined             : fixed priority, lowest eligible index wins
//
// Ports
//   clock, reset   : single clock, synchronous active-high reset
//   word_read      : per-PU level request, held until that PU's word_ready
//   word_counter   : per-PU 32-bit word index, PU i at [32i +: 32]
//   base_addr      : per-PU region base, PU i at [ADDR_W*i +: ADDR_W]
//   sram_rd_en     : one-cycle SRAM read strobe
//   sram_addr      : SRAM word address, valid with sram_rd_en
//   sram_rdata     : SRAM data, valid SRAM_LAT cycles after sram_rd_en
//   word_ready     : one-hot one-cycle data-valid pulse to the granted PU
//   SRAM_out       : registered read word broadcast to all PUs
//   grant_id       : index of the PU being served
//   busy           : high whenever the FSM is not in IDLE
module weight_sram_arbiter #(
  parameter int NUM_PU          = 4,
  parameter int ADDR_W          = 16,
  parameter int SRAM_LAT        = 1,
  parameter int WEIGHT_SRAM_LEN = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PU-1:0]            word_read,
  input  logic [NUM_PU*32-1:0]         word_counter,
  input  logic [NUM_PU*ADDR_W-1:0]     base_addr,
  output logic                         sram_rd_en,
  output logic [ADDR_W-1:0]            sram_addr,
  input  logic [WEIGHT_SRAM_LEN-1:0]   sram_rdata,
  output logic [NUM_PU-1:0]            word_ready,
  output logic [WEIGHT_SRAM_LEN-1:0]   SRAM_out,
  output logic [$clog2(NUM_PU)-1:0]    grant_id,
  output logic                         busy
);

  localparam int          GW    = $clog2(NUM_PU);
  localparam int          CNT_W = 3;
  localparam int unsigned NPU   = NUM_PU;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        just_ret_q, just_ret_d;
  logic                        sram_rd_en_q, sram_rd_en_d;
  logic [ADDR_W-1:0]           sram_addr_q, sram_addr_d;
  logic [NUM_PU-1:0]           word_ready_q, word_ready_d;
  logic [WEIGHT_SRAM_LEN-1:0]  sram_out_q, sram_out_d;
  logic                        busy_q, busy_d;
`ifndef WEIGHT_ARB_FIXED_PRIORITY_EN
  logic [GW-1:0]               rr_ptr_q, rr_ptr_d;
`endif

  // Arbitration
  logic [NUM_PU-1:0] mask;
  logic [NUM_PU-1:0] elig;
  logic              any_elig;
  logic [GW-1:0]     win;

  always_comb begin
    // The PU served last is masked for the one IDLE cycle right after
    // RETURN, so a requester that has not yet dropped word_read is not
    // granted a second read for the same word.
    mask     = just_ret_q ? (NUM_PU'(1) << grant_q) : '0;
    elig     = word_read & ~mask;
    any_elig = 1'b0;
    win      = '0;
`ifdef WEIGHT_ARB_FIXED_PRIORITY_EN
    for (int unsigned i = 0; i < NPU; i++) begin
      if (!any_elig && elig[GW'(i)]) begin
        any_elig = 1'b1;
        win      = GW'(i);
      end
    end
`else
    for (int unsigned i = 0; i < NPU; i++) begin
      int unsigned   idx;
      logic [GW-1:0] idx_g;
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NPU) idx = idx - NPU;
      idx_g = GW'(idx);
      if (!any_elig && elig[idx_g]) begin
        any_elig = 1'b1;
        win      = idx_g;
      end
    end
`endif
  end

  // Address of the winner, truncated to ADDR_W (wraps silently)
  logic [ADDR_W-1:0] base_sel;
  logic [31:0]       wc_sel;
  logic              unused_wc_hi;

  always_comb begin
    base_sel = base_addr[win*ADDR_W +: ADDR_W];
    wc_sel   = word_counter[win*32 +: 32];
  end

  assign unused_wc_hi = ^wc_sel;

  // Next-state logic; every output is the flop of its _d value
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    just_ret_d   = 1'b0;
    sram_rd_en_d = 1'b0;
    sram_addr_d  = sram_addr_q;
    word_ready_d = '0;
    sram_out_d   = sram_out_q;
    busy_d       = busy_q;
`ifndef WEIGHT_ARB_FIXED_PRIORITY_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d      = ISSUE;
          grant_d      = win;
          sram_rd_en_d = 1'b1;
          sram_addr_d  = base_sel + wc_sel[ADDR_W-1:0];
          busy_d       = 1'b1;
`ifndef WEIGHT_ARB_FIXED_PRIORITY_EN
          rr_ptr_d     = (win == GW'(NUM_PU-1)) ? '0 : win + GW'(1);
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(SRAM_LAT-1)) begin
          state_d      = RETURN;
          sram_out_d   = sram_rdata;
          word_ready_d = NUM_PU'(1) << grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RETURN: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        just_ret_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      cnt_q        <= '0;
      just_ret_q   <= 1'b0;
      sram_rd_en_q <= 1'b0;
      sram_addr_q  <= '0;
      word_ready_q <= '0;
      sram_out_q   <= '0;
      busy_q       <= 1'b0;
`ifndef WEIGHT_ARB_FIXED_PRIORITY_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      just_ret_q   <= just_ret_d;
      sram_rd_en_q <= sram_rd_en_d;
      sram_addr_q  <= sram_addr_d;
      word_ready_q <= word_ready_d;
      sram_out_q   <= sram_out_d;
      busy_q       <= busy_d;
`ifndef WEIGHT_ARB_FIXED_PRIORITY_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign sram_rd_en = sram_rd_en_q;
  assign sram_addr  = sram_addr_q;
  assign word_ready = word_ready_q;
  assign SRAM_out   = sram_out_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Directed bench for weight_sram_arbiter: u_dut uses SRAM_LAT=1 with an SRAM
// model returning {16'hC0DE, addr}; u_lat3 uses SRAM_LAT=3 with constant data.
module tb_weight_sram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM_LAT = 1 instance
  logic         reset;
  logic [3:0]   word_read;
  logic [127:0] word_counter;
  logic [63:0]  base_addr;
  logic         sram_rd_en;
  logic [15:0]  sram_addr;
  logic [31:0]  sram_rdata = '0;
  logic [3:0]   word_ready;
  logic [31:0]  SRAM_out;
  logic [1:0]   grant_id;
  logic         busy;

  // SRAM_LAT = 3 instance
  logic         reset_b;
  logic [3:0]   word_read_b;
  logic [127:0] word_counter_b;
  logic [63:0]  base_addr_b;
  logic         sram_rd_en_b;
  logic [15:0]  sram_addr_b;
  logic [31:0]  sram_rdata_b;
  logic [3:0]   word_ready_b;
  logic [31:0]  SRAM_out_b;
  logic [1:0]   grant_id_b;
  logic         busy_b;

  int tests = 0;
  int fails = 0;
  int exp_g [5];
  logic [3:0] ready_seen;

  weight_sram_arbiter #(.NUM_PU(4), .ADDR_W(16), .SRAM_LAT(1), .WEIGHT_SRAM_LEN(32)) u_dut (
    .clock(clock), .reset(reset), .word_read(word_read), .word_counter(word_counter),
    .base_addr(base_addr), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .word_ready(word_ready), .SRAM_out(SRAM_out),
    .grant_id(grant_id), .busy(busy)
  );

  weight_sram_arbiter #(.NUM_PU(4), .ADDR_W(16), .SRAM_LAT(3), .WEIGHT_SRAM_LEN(32)) u_lat3 (
    .clock(clock), .reset(reset_b), .word_read(word_read_b), .word_counter(word_counter_b),
    .base_addr(base_addr_b), .sram_rd_en(sram_rd_en_b), .sram_addr(sram_addr_b),
    .sram_rdata(sram_rdata_b), .word_ready(word_ready_b), .SRAM_out(SRAM_out_b),
    .grant_id(grant_id_b), .busy(busy_b)
  );

  // One-cycle-latency SRAM: data tagged with the address it was read from
  always @(posedge clock) begin
    if (sram_rd_en) sram_rdata <= {16'hC0DE, sram_addr};
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pu(input int i, input logic [15:0] b, input logic [31:0] w);
    base_addr[i*16 +: 16]    = b;
    word_counter[i*32 +: 32] = w;
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    word_read = '0;
    step();
    reset     = 1'b0;
  endtask

  initial begin
`ifdef WEIGHT_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 1, 0, 1, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    reset          = 1'b1;
    reset_b        = 1'b1;
    word_read      = '0;
    word_counter   = '0;
    base_addr      = '0;
    word_read_b    = '0;
    word_counter_b = '0;
    base_addr_b    = '0;
    sram_rdata_b   = 32'hDEAD_BEEF;
    step();
    step();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(word_ready), 0);
    chk("rst_rd_en", 32'(sram_rd_en), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_out", SRAM_out, 0);
    chk("rst_grant", 32'(grant_id), 0);

    // Single request from PU1, latency c+1 issue, c+3 ready
    reset   = 1'b0;
    reset_b = 1'b0;
    set_pu(1, 16'h0100, 32'd5);
    word_read = 4'b0010;
    step();
    chk("single_rd_en", 32'(sram_rd_en), 1);
    chk("single_addr", 32'(sram_addr), 32'h0105);
    chk("single_grant", 32'(grant_id), 1);
    chk("single_busy", 32'(busy), 1);
    chk("single_noready_c1", 32'(word_ready), 0);
    step();
    chk("single_rd_en_c2", 32'(sram_rd_en), 0);
    chk("single_noready_c2", 32'(word_ready), 0);
    step();
    chk("single_ready", 32'(word_ready), 32'b0010);
    chk("single_data", SRAM_out, 32'hC0DE_0105);
    word_read = '0;
    step();
    chk("single_ready_clr", 32'(word_ready), 0);
    chk("single_idle", 32'(busy), 0);

    // All four PUs requesting continuously
    pulse_reset();
    for (int i = 0; i < 4; i++) set_pu(i, 16'(i * 16'h1000), 32'(i));
    word_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("all_grant", 32'(grant_id), 32'(exp_g[k]));
      chk("all_rd_en", 32'(sram_rd_en), 1);
      chk("all_addr", 32'(sram_addr), 32'(exp_g[k] * 4096 + exp_g[k]));
      step();
      step();
      chk("all_ready", 32'(word_ready), 32'(1 << exp_g[k]));
      step();
      chk("all_gap_idle", 32'(busy), 0);
    end
    word_read = '0;

    // Stalled PU2 keeps word_read high for 3 cycles after its word_ready
    pulse_reset();
    set_pu(2, 16'h0200, 32'd7);
    set_pu(0, 16'h0000, 32'h11);
    word_read = 4'b0100;
    step();
    chk("stall_grant2", 32'(grant_id), 2);
    chk("stall_addr2", 32'(sram_addr), 32'h0207);
    step();
    step();
    chk("stall_ready2", 32'(word_ready), 32'b0100);
    chk("stall_data2", SRAM_out, 32'hC0DE_0207);
    word_read = 4'b0101;
    step();
    chk("stall_masked_idle", 32'(busy), 0);
    step();
    chk("stall_next_grant", 32'(grant_id), 0);
    chk("stall_next_rd_en", 32'(sram_rd_en), 1);
    chk("stall_next_addr", 32'(sram_addr), 32'h0011);
    step();
    step();
    chk("stall_ready0", 32'(word_ready), 32'b0001);
    word_read = '0;
    ready_seen = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      ready_seen = ready_seen | {3'b000, sram_rd_en};
    end
    chk("stall_no_extra_read", 32'(ready_seen), 0);

    // Address wrap, and word_read dropped while granted
    pulse_reset();
    set_pu(0, 16'hFFFE, 32'd3);
    word_read = 4'b0001;
    step();
    chk("wrap_addr", 32'(sram_addr), 32'h0001);
    chk("wrap_rd_en", 32'(sram_rd_en), 1);
    word_read = '0;
    step();
    step();
    chk("abort_ready", 32'(word_ready), 32'b0001);
    chk("abort_data", SRAM_out, 32'hC0DE_0001);
    step();
    chk("abort_ready_clr", 32'(word_ready), 0);
    chk("abort_idle", 32'(busy), 0);

    // SRAM_LAT=3: full transaction, then reset during WAIT
    word_read_b = 4'b0001;
    step();
    chk("lat3_rd_en", 32'(sram_rd_en_b), 1);
    step();
    step();
    step();
    chk("lat3_noready_c4", 32'(word_ready_b), 0);
    step();
    chk("lat3_ready_c5", 32'(word_ready_b), 32'b0001);
    chk("lat3_data", SRAM_out_b, 32'hDEAD_BEEF);
    word_read_b = '0;
    step();
    step();
    word_read_b = 4'b0001;
    step();
    chk("lat3b_rd_en", 32'(sram_rd_en_b), 1);
    step();
    step();
    reset_b     = 1'b1;
    word_read_b = '0;
    step();
    reset_b = 1'b0;
    chk("midrst_busy", 32'(busy_b), 0);
    chk("midrst_ready", 32'(word_ready_b), 0);
    chk("midrst_out", SRAM_out_b, 0);
    ready_seen = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      ready_seen = ready_seen | word_ready_b;
    end
    chk("midrst_no_pulse", 32'(ready_seen), 0);
    chk("midrst_data_ignored", SRAM_out_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_sram_arbiter.md
WEIGHT_SRAM_ARBITER -- requirements
Module: weight_sram_arbiter

Interface
REQ-001 Parameter NUM_PU, default 4, number of unique-weight-buffer requesters (2..16).
REQ-002 Parameter ADDR_W, default 16, weight SRAM word-address width.
REQ-003 Parameter SRAM_LAT, default 1, SRAM read latency in cycles from sram_rd_en to valid sram_rdata (1..4).
REQ-004 Reset is synchronous and active-high; the block uses one clock; clock and reset ports are named clock and reset.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 word_read  in  NUM_PU  per-PU level request, held high until that PU's word_ready pulse.
REQ-008 word_counter  in  NUM_PU*32  per-PU word index, flattened, PU i at bits [32i +: 32].
REQ-009 base_addr  in  NUM_PU*ADDR_W  per-PU weight region base address, flattened.
REQ-010 sram_rd_en  out  1  single-cycle SRAM read strobe.
REQ-011 sram_addr  out  ADDR_W  SRAM read address, valid while sram_rd_en=1.
REQ-012 sram_rdata  in  WEIGHT_SRAM_LEN  SRAM read data, valid SRAM_LAT cycles after sram_rd_en.
REQ-013 word_ready  out  NUM_PU  one-hot single-cycle data-valid pulse to the granted PU.
REQ-014 SRAM_out  out  WEIGHT_SRAM_LEN  registered read word, broadcast to all PUs, valid while any word_ready bit is 1.
REQ-015 grant_id  out  clog2(NUM_PU)  index of the PU currently served.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RETURN.
REQ-018 IDLE: if any eligible word_read bit is high, latch the winner into grant_id and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: sram_rd_en=1 and sram_addr=base_addr[g]+word_counter[g][ADDR_W-1:0] (modulo 2^ADDR_W, wrap with no error); go to WAIT.
REQ-020 WAIT: count SRAM_LAT cycles, capture sram_rdata into SRAM_out at the end of the final count, then go to RETURN.
REQ-021 RETURN: word_ready[g]=1 for exactly one cycle with SRAM_out stable; go to IDLE.
REQ-022 Latency: a request first seen in IDLE at cycle c produces word_ready at cycle c+2+SRAM_LAT (c+3 when SRAM_LAT=1).
REQ-023 Eligibility: in the cycle directly after RETURN, the PU just served is masked, so a still-high word_read from a stalled PU is never granted twice for one read.
REQ-024 Default arbitration is round-robin: search starts at rr_ptr and ascends modulo NUM_PU; after each grant, rr_ptr=(g+1) mod NUM_PU.
REQ-025 A word_read deasserted while that PU is granted does not abort the transaction; the read completes and word_ready still pulses.
REQ-026 New requests arriving while not in IDLE are held pending and are not lost; at most one SRAM read is outstanding at any time.
REQ-027 word_ready, sram_rd_en and busy are decoded from registered state only, with no combinational path from word_read.

Reset
REQ-028 On reset, the state returns to IDLE and rr_ptr, grant_id, SRAM_out, word_ready, sram_rd_en, sram_addr and busy all clear to 0.
REQ-029 Reset asserted mid-transaction discards the in-flight read; no word_ready pulse follows, and sram_rdata arriving after reset is ignored.

Configuration
REQ-030 With macro WEIGHT_ARB_FIXED_PRIORITY_EN defined, arbitration is fixed priority (lowest eligible index wins) and rr_ptr is not implemented.
REQ-031 Without WEIGHT_ARB_FIXED_PRIORITY_EN, round-robin per REQ-024 applies.

Verification
REQ-032 Single request: word_read=4'b0010, base_addr[1]=0x100, word_counter[1]=5, SRAM_LAT=1 -> sram_rd_en at c+1 with sram_addr=0x105; word_ready=4'b0010 at c+3 with SRAM_out equal to the SRAM data.
REQ-033 All four PUs requesting continuously, round-robin -> grant order 0,1,2,3,0; each grant is 4 cycles apart; no PU is served twice in a row.
REQ-034 Same stimulus with WEIGHT_ARB_FIXED_PRIORITY_EN defined -> PU0 is served, PU1 in the masked cycle, then PU0 again; PU3 is starved while PU0 and PU1 keep requesting.
REQ-035 Stalled requester: PU2 keeps word_read high for 3 cycles after its word_ready -> exactly one SRAM read is issued for PU2 before another eligible PU is served.
REQ-036 Reset during WAIT with SRAM_LAT=3 -> the next cycle shows busy=0 and word_ready=0, and no pulse follows.
REQ-037 Address wrap: base_addr=0xFFFE, word_counter=3, ADDR_W=16 -> sram_addr=0x0001.
